// File: rtl/io_timer_intr.sv
// io_timer_intr: memory-mapped down-counter timer with interrupt handshake.
// Ports: clk/reset (async, active-high), io_cs/io_rd/io_wr/Address/IO_in
// from the CPU I/O bus, IO_out tri-stated read bus, int_ack in, intr out.
// Registers at BASE_ADDR: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS,
// 0x10 FIRES. The decode window is 32 bytes; offsets 0x14-0x1C read 0.
module io_timer_intr #(
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [11:0] Address,
    input  logic [31:0] IO_in,
    output logic [31:0] IO_out,
    input  logic        int_ack,
    output logic        intr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIRE,
        ACKWAIT
    } state_t;

    state_t           state_q, state_n;
    logic             en_q, en_n;
    logic             auto_q, auto_n;
    logic             ovr_q, ovr_n;
    logic [CNT_W-1:0] load_q, load_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [31:0]      fires_q, fires_n;

    // Address decode; byte lanes are ignored.
    logic [9:0]  word_off;
    logic        hit;
    logic [2:0]  idx;
    logic        rd_en;
    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_stat;
    logic [31:0] rd_data;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^Address[1:0];
    assign word_off = Address[11:2] - BASE_ADDR[11:2];
    assign hit      = (word_off[9:3] == 7'd0);
    assign idx      = word_off[2:0];
    assign rd_en    = io_cs & io_rd & hit;
    assign wr_en    = io_cs & io_wr & hit;
    assign wr_ctrl  = wr_en & (idx == 3'd0);
    assign wr_load  = wr_en & (idx == 3'd1);
    assign wr_stat  = wr_en & (idx == 3'd3);

    assign intr = (state_q == FIRE);

    always_comb begin
        rd_data = 32'd0;
        case (idx)
            3'd0:    rd_data = {30'd0, auto_q, en_q};
            3'd1:    rd_data = 32'(load_q);
            3'd2:    rd_data = 32'(count_q);
            3'd3:    rd_data = {30'd0, ovr_q, intr};
            3'd4:    rd_data = fires_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign IO_out = rd_en ? rd_data : 32'hz;

    // Counting continues through the handshake only in auto-reload mode.
    logic counting;
    logic terminal;

    assign counting = (state_q == RUN) ||
                      (((state_q == FIRE) || (state_q == ACKWAIT)) && auto_q);
    assign terminal = counting && (count_q <= CNT_W'(1));

    always_comb begin
        state_n = state_q;
        en_n    = en_q;
        auto_n  = auto_q;
        ovr_n   = ovr_q;
        load_n  = load_q;
        count_n = count_q;
        fires_n = fires_q;

        if (counting) begin
            if (terminal)
                count_n = auto_q ? load_q : '0;
            else
                count_n = count_q - CNT_W'(1);
        end

        // Clear first so a same-edge overrun still sets the flag.
        if (wr_stat && IO_in[1])
            ovr_n = 1'b0;

        unique case (state_q)
            IDLE: ;
            RUN: begin
                if (terminal)
                    state_n = FIRE;
            end
            FIRE: begin
                if (terminal)
                    ovr_n = 1'b1;
                if (int_ack) begin
                    state_n = ACKWAIT;
                    fires_n = fires_q + 32'd1;
                end
            end
            ACKWAIT: begin
                if (terminal)
                    ovr_n = 1'b1;
                if (!int_ack)
                    state_n = (en_q && auto_q) ? RUN : IDLE;
            end
        endcase

        // LOAD update never affects this edge's reload (load_q used above).
        if (wr_load)
            load_n = IO_in[CNT_W-1:0];

        // A CPU CTRL write overrides the timer for COUNT and state.
        if (wr_ctrl) begin
            en_n   = IO_in[0];
            auto_n = IO_in[1];
            if (!IO_in[0]) begin
                state_n = IDLE;
                count_n = count_q;
                fires_n = fires_q;
            end else begin
                count_n = load_q;
                if ((state_q == IDLE) || (state_q == RUN))
                    state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ovr_q   <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            fires_q <= 32'd0;
        end else begin
            state_q <= state_n;
            en_q    <= en_n;
            auto_q  <= auto_n;
            ovr_q   <= ovr_n;
            load_q  <= load_n;
            count_q <= count_n;
            fires_q <= fires_n;
        end
    end

endmodule

// File: tb/tb_io_timer_intr.sv
// tb_io_timer_intr: directed self-checking bench for io_timer_intr.
// The read bus is a pulled-up net, so an undriven bus reads all ones.
`timescale 1ns/1ps
module tb_io_timer_intr;

    localparam logic [11:0] BASE   = 12'h040;
    localparam logic [11:0] A_CTRL = BASE + 12'h000;
    localparam logic [11:0] A_LOAD = BASE + 12'h004;
    localparam logic [11:0] A_CNT  = BASE + 12'h008;
    localparam logic [11:0] A_STAT = BASE + 12'h00C;
    localparam logic [11:0] A_FIRE = BASE + 12'h010;
    localparam logic [31:0] HIZ    = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [11:0] Address;
    logic [31:0] IO_in;
    tri1  [31:0] io_bus;
    logic        int_ack;
    logic        intr;

    int errors = 0;
    int checks = 0;

    io_timer_intr #(
        .BASE_ADDR (BASE),
        .CNT_W     (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_cs   (io_cs),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .Address (Address),
        .IO_in   (IO_in),
        .IO_out  (io_bus),
        .int_ack (int_ack),
        .intr    (intr)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [11:0] a,
                        input logic cs, input logic [31:0] exp);
        logic [31:0] d;
        io_cs   = cs;
        io_rd   = 1'b1;
        Address = a;
        #1;
        d = io_bus;
        io_cs = 1'b0;
        io_rd = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        io_cs   = 1'b1;
        io_wr   = 1'b1;
        Address = a;
        IO_in   = d;
        @(posedge clk);
        #1;
        io_cs = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ack(input logic v);
        @(negedge clk);
        int_ack = v;
    endtask

    initial begin
        reset   = 1'b1;
        io_cs   = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        Address = 12'h000;
        IO_in   = 32'd0;
        int_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and decode
        check("rst_intr", {31'd0, intr}, 32'd0);
        rchk("rst_ctrl", A_CTRL, 1'b1, 32'd0);
        rchk("rst_load", A_LOAD, 1'b1, 32'd0);
        rchk("rst_cnt", A_CNT, 1'b1, 32'd0);
        rchk("rst_stat", A_STAT, 1'b1, 32'd0);
        rchk("rst_fires", A_FIRE, 1'b1, 32'd0);
        rchk("unmapped_14", BASE + 12'h014, 1'b1, 32'd0);
        rchk("hiz_base20", BASE + 12'h020, 1'b1, HIZ);
        rchk("hiz_below", BASE - 12'h004, 1'b1, HIZ);
        rchk("hiz_nocs", A_CTRL, 1'b0, HIZ);

        // One-shot, LOAD=5
        bus_write(A_LOAD, 32'd5);
        rchk("load5", A_LOAD, 1'b1, 32'd5);
        bus_write(A_CTRL, 32'd1);
        rchk("os_cnt0", A_CNT, 1'b1, 32'd5);
        check("os_intr0", {31'd0, intr}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            rchk($sformatf("os_cnt%0d", i), A_CNT, 1'b1, 32'(5 - i));
            check($sformatf("os_intr%0d", i), {31'd0, intr}, 32'd0);
        end
        tick;
        check("os_fire", {31'd0, intr}, 32'd1);
        rchk("os_cnt_term", A_CNT, 1'b1, 32'd0);
        rchk("os_stat_pend", A_STAT, 1'b1, 32'd1);
        set_ack(1'b1);
        tick;
        check("os_ack_intr", {31'd0, intr}, 32'd0);
        rchk("os_fires1", A_FIRE, 1'b1, 32'd1);
        set_ack(1'b0);
        tick;
        repeat (3) tick;
        check("os_idle_intr", {31'd0, intr}, 32'd0);
        rchk("os_idle_cnt", A_CNT, 1'b1, 32'd0);

        // Auto-reload, LOAD=3, ack held ten edges
        bus_write(A_LOAD, 32'd3);
        bus_write(A_CTRL, 32'd3);
        rchk("au_cnt0", A_CNT, 1'b1, 32'd3);
        tick;
        rchk("au_cnt1", A_CNT, 1'b1, 32'd2);
        tick;
        rchk("au_cnt2", A_CNT, 1'b1, 32'd1);
        tick;
        check("au_fire", {31'd0, intr}, 32'd1);
        rchk("au_reload", A_CNT, 1'b1, 32'd3);
        set_ack(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick;
            check($sformatf("au_hold%0d", i), {31'd0, intr}, 32'd0);
        end
        rchk("au_ovr", A_STAT, 1'b1, 32'd2);
        rchk("au_fires2", A_FIRE, 1'b1, 32'd2);
        set_ack(1'b0);
        tick;
        check("au_rel_intr", {31'd0, intr}, 32'd0);
        rchk("au_rel_cnt", A_CNT, 1'b1, 32'd1);
        tick;
        check("au_refire", {31'd0, intr}, 32'd1);
        rchk("au_refire_cnt", A_CNT, 1'b1, 32'd3);
        bus_write(A_STAT, 32'd2);
        rchk("au_w1c", A_STAT, 1'b1, 32'd1);
        rchk("au_w1c_cnt", A_CNT, 1'b1, 32'd2);

        // Disable while intr is pending
        bus_write(A_CTRL, 32'hFFFF_FFFE);
        check("dis_intr", {31'd0, intr}, 32'd0);
        rchk("dis_cnt_hold", A_CNT, 1'b1, 32'd2);
        rchk("dis_ctrl", A_CTRL, 1'b1, 32'd2);
        set_ack(1'b1);
        tick;
        set_ack(1'b0);
        tick;
        rchk("dis_fires", A_FIRE, 1'b1, 32'd2);
        check("dis_intr2", {31'd0, intr}, 32'd0);
        rchk("dis_cnt2", A_CNT, 1'b1, 32'd2);

        // LOAD=0 fires one edge after enable
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'd1);
        check("l0_intr0", {31'd0, intr}, 32'd0);
        tick;
        check("l0_fire", {31'd0, intr}, 32'd1);
        rchk("l0_stat", A_STAT, 1'b1, 32'd1);

        // Asynchronous reset mid-handshake
        set_ack(1'b1);
        #1;
        check("ar_pre", {31'd0, intr}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar_intr", {31'd0, intr}, 32'd0);
        int_ack = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        reset = 1'b0;
        #1;
        rchk("ar_ctrl", A_CTRL, 1'b1, 32'd0);
        rchk("ar_load", A_LOAD, 1'b1, 32'd0);
        rchk("ar_cnt", A_CNT, 1'b1, 32'd0);
        rchk("ar_stat", A_STAT, 1'b1, 32'd0);
        rchk("ar_fires", A_FIRE, 1'b1, 32'd0);
        tick;
        check("ar_intr2", {31'd0, intr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
